pe_mac_array: RTL and testbench
===============================

Name: pe_mac_array

Overview:
- Next-generation GeMM processing element with LANES parallel fixed-point MAC lanes sharing one broadcast weight.
- Two modes:
  - CONV: accumulate LEN products per output.
  - FIX_MAC: per-element scale/bias, used for BN.
- Sits in the systolic array in place of the single-lane PE; forwards data/weight to its neighbour.
- Adds a valid/ready result handshake with pipeline stall, rounding/saturation, and per-lane scale/bias.

Parameters:
- LANES, 4, number of parallel MAC lanes
- DATA_WIDTH, 16, signed fixed-point operand/result width
- FRAC_BITS, 8, fractional bits of operands/results
- ACC_WIDTH, 40, signed accumulator width (≥ 2*DATA_WIDTH + log2 max LEN)
- LEN_WIDTH, 16, width of the accumulation-length register

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_i  in  4  command code
- cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o
- param_i  in  LEN_WIDTH  scalar parameter (LEN, mode)
- param_vec_i  in  LANES*DATA_WIDTH  per-lane parameter (mul, add, acc preload)
- data_i  in  LANES*DATA_WIDTH  per-lane activations
- weight_i  in  DATA_WIDTH  broadcast weight
- data_o  out  LANES*DATA_WIDTH  registered data pass-through
- weight_o  out  DATA_WIDTH  registered weight pass-through
- result_o  out  LANES*DATA_WIDTH  per-lane result
- result_valid_o  out  1  result valid
- result_ready_i  in  1  downstream accepts result
- busy_o  out  1  group or op in flight
- cfg_err_o  out  1  sticky: config command issued while busy

Behaviour:
- **Reset (async, rst_ni=0):**
  - All outputs, registers and pipeline valids go to 0; LEN=1, mode=CONV, mul=0, add=0.
  - Takes effect immediately, including mid-group; in-flight work is discarded.
- **Stall:** stall = result_valid_o && !result_ready_i; cmd_ready_o = !stall.
  - While stalled, every pipeline register, counter and output holds.
- **Commands** (accepted only when cmd_ready_o=1):
  - 0 NOP.
  - 1 CLEAR: zero accumulators, term counter, S1/S2 valids, result_valid_o, busy_o and cfg_err_o.
  - 2 TRIGGER: capture operands into S1; data_o/weight_o <= inputs.
  - 3 FORWARD: data_o/weight_o <= inputs only; no MAC.
  - 4 SET_LEN: LEN <= param_i; a value of 0 is stored as 1.
  - 5 SET_MUL: mul[l] <= param_vec_i lane l.
  - 6 SET_ADD: add[l] <= param_vec_i lane l.
  - 7 SET_MODE: mode <= param_i[0] (0 = CONV, 1 = FIX_MAC).
  - 8 LOAD_ACC: acc[l] <= sign-extended lane value << FRAC_BITS (bias for the next group).
  - Codes 9-15 behave as NOP.
- **Config guard:** SET_LEN, SET_MODE and LOAD_ACC while busy_o=1 are ignored and set cfg_err_o.
- **Pipeline:**
  - S1 (cycle t+1): p[l] = data[l]*weight (CONV) or data[l]*mul[l] (FIX_MAC); full 2*DATA_WIDTH signed product.
  - S2 (cycle t+2): accumulate/format.
  - Latency from accepted final TRIGGER to result_valid_o = 2 cycles.
- **CONV mode:**
  - S2: acc[l] += sext(p[l]); term counter increments.
  - On term LEN-1: result[l] = fmt(acc[l] + p[l]); then acc <= 0 and counter <= 0.
- **FIX_MAC mode:** every trigger yields result[l] = fmt(p[l] + (add[l] << FRAC_BITS)); counter unused.
- **fmt(x):**
  - Add 2^(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS (round half up).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- **Result register:**
  - Loads when S2 produces a result and no stall.
  - result_valid_o stays high until the handshake completes.
  - Transfer and new load in the same cycle are allowed; result_o is stable while valid && !ready.
- **busy_o:**
  - CONV: set on an accepted TRIGGER; cleared the cycle the group result loads, or on CLEAR.
  - FIX_MAC: high while S1 or S2 holds a valid op.
- **Accumulator overflow:** ACC_WIDTH wrap is undefined use; the bench constrains LEN accordingly.

Test Plan:
- CONV dot product: LANES=4, DW=16, FRAC=8; SET_LEN 3; data all 0x0100; weights 0x0200, 0x0100, 0x0080 → 2 cycles after the 3rd TRIGGER, every result lane = 0x0380 and result_valid_o=1; busy_o falls the same cycle.
- Saturation and rounding:
  - SET_LEN 2, data 0x7F00, weight 0x7F00 → 0x7FFF.
  - data 0x8100, weight 0x7F00 → 0x8000.
  - SET_LEN 1, data 0x0001, weight 0x0080 (product 0x80) → 0x0001.
- FIX_MAC: SET_MODE 1; mul=0x0200, add=0x0080; 4 back-to-back TRIGGERs with data 0x0100 → 4 consecutive results of 0x0280, each 2 cycles after its trigger.
- Backpressure: hold result_ready_i=0 after a CONV result, then issue a TRIGGER → cmd_ready_o=0 and result_o stable; raise ready → one transfer, then cmd_ready_o=1 the next cycle.
- Bias and guard:
  - LOAD_ACC 0x0100 per lane, then LEN=1, data 0x0100, weight 0x0100 → 0x0200.
  - SET_LEN mid-group → ignored and cfg_err_o=1; CLEAR → cfg_err_o=0.
- Async reset mid-group: drop rst_ni between clock edges after 2 of 3 TRIGGERs → all outputs 0 before the next edge; after release, LEN=1 and mode=CONV.

Source files
------------

// File: rtl/pe_mac_array_if.sv
// Command, operand and result bundle for the multi-lane MAC processing element.
// The master drives commands and operands and accepts results; the slave is the PE.
interface pe_mac_array_if #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16
);

  logic                          cmd_valid_i;
  logic [3:0]                    cmd_i;
  logic                          cmd_ready_o;
  logic [LEN_WIDTH-1:0]          param_i;
  logic [LANES*DATA_WIDTH-1:0]   param_vec_i;
  logic [LANES*DATA_WIDTH-1:0]   data_i;
  logic [DATA_WIDTH-1:0]         weight_i;
  logic [LANES*DATA_WIDTH-1:0]   data_o;
  logic [DATA_WIDTH-1:0]         weight_o;
  logic [LANES*DATA_WIDTH-1:0]   result_o;
  logic                          result_valid_o;
  logic                          result_ready_i;
  logic                          busy_o;
  logic                          cfg_err_o;

  modport master (
    output cmd_valid_i, cmd_i, param_i, param_vec_i, data_i, weight_i, result_ready_i,
    input  cmd_ready_o, data_o, weight_o, result_o, result_valid_o, busy_o, cfg_err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_i, param_i, param_vec_i, data_i, weight_i, result_ready_i,
    output cmd_ready_o, data_o, weight_o, result_o, result_valid_o, busy_o, cfg_err_o
  );

endinterface

// File: rtl/pe_mac_array.sv
// Multi-lane fixed-point MAC processing element with a shared broadcast weight.
// CONV mode accumulates LEN products per output; FIX_MAC mode applies a per-lane
// scale and bias to every operand. Results leave through a valid/ready register
// that stalls the whole pipeline while it is full and not accepted.
module pe_mac_array #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  pe_mac_array_if.slave  bus
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned VW = LANES * DATA_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] ONE     = ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] RND     = ONE << (FRAC_BITS - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = (ONE << (DATA_WIDTH - 1)) - ONE;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [3:0] {
    CMD_NOP      = 4'd0,
    CMD_CLEAR    = 4'd1,
    CMD_TRIGGER  = 4'd2,
    CMD_FORWARD  = 4'd3,
    CMD_SET_LEN  = 4'd4,
    CMD_SET_MUL  = 4'd5,
    CMD_SET_ADD  = 4'd6,
    CMD_SET_MODE = 4'd7,
    CMD_LOAD_ACC = 4'd8
  } cmd_e;

  typedef enum logic {
    MODE_CONV = 1'b0,
    MODE_FIX  = 1'b1
  } mode_e;

  logic                          stall, accept;
  logic                          do_clear, do_trig, do_fwd, do_len, do_mul, do_add, do_mode, do_load;
  logic                          busy;

  logic [LEN_WIDTH-1:0]          len_q, cnt_q;
  mode_e                         mode_q;
  logic signed [DATA_WIDTH-1:0]  mul_q [LANES];
  logic signed [DATA_WIDTH-1:0]  add_q [LANES];
  logic signed [ACC_WIDTH-1:0]   acc_q [LANES];
  logic signed [PW-1:0]          prod_q [LANES];
  logic                          s1_valid_q;
  logic                          busy_q, res_valid_q, cfg_err_q;
  logic [VW-1:0]                 result_q, data_q;
  logic [DATA_WIDTH-1:0]         weight_q;

  logic [DATA_WIDTH-1:0]         lane_op [LANES];
  logic signed [PW-1:0]          prod_c [LANES];
  logic signed [ACC_WIDTH-1:0]   sum_c [LANES];
  logic signed [ACC_WIDTH-1:0]   rnd_c [LANES];
  logic [VW-1:0]                 res_c;
  logic                          last_term, s2_fire, res_load;

  assign stall  = res_valid_q && !bus.result_ready_i;
  assign accept = bus.cmd_valid_i && !stall;

  // Command decode; only accepted commands raise a strobe.
  always_comb begin
    do_clear = 1'b0;
    do_trig  = 1'b0;
    do_fwd   = 1'b0;
    do_len   = 1'b0;
    do_mul   = 1'b0;
    do_add   = 1'b0;
    do_mode  = 1'b0;
    do_load  = 1'b0;
    if (accept) begin
      case (bus.cmd_i)
        CMD_CLEAR:    do_clear = 1'b1;
        CMD_TRIGGER:  do_trig  = 1'b1;
        CMD_FORWARD:  do_fwd   = 1'b1;
        CMD_SET_LEN:  do_len   = 1'b1;
        CMD_SET_MUL:  do_mul   = 1'b1;
        CMD_SET_ADD:  do_add   = 1'b1;
        CMD_SET_MODE: do_mode  = 1'b1;
        CMD_LOAD_ACC: do_load  = 1'b1;
        default:      ;
      endcase
    end
  end

  // In FIX_MAC there is no group, so busy simply tracks ops still in the pipe.
  assign busy = (mode_q == MODE_FIX) ? (s1_valid_q || res_valid_q) : busy_q;

  assign last_term = (cnt_q == len_q - LEN_WIDTH'(1));
  assign s2_fire   = s1_valid_q && !stall;
  assign res_load  = s2_fire && ((mode_q == MODE_FIX) || last_term);

  // S1 products and S2 accumulate/round/saturate datapath per lane.
  always_comb begin
    res_c = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_op[l] = (mode_q == MODE_FIX) ? mul_q[l] : bus.weight_i;
      prod_c[l]  = $signed({{DATA_WIDTH{bus.data_i[l*DATA_WIDTH+DATA_WIDTH-1]}},
                            bus.data_i[l*DATA_WIDTH +: DATA_WIDTH]})
                 * $signed({{DATA_WIDTH{lane_op[l][DATA_WIDTH-1]}}, lane_op[l]});
      if (mode_q == MODE_FIX) begin
        sum_c[l] = {{(ACC_WIDTH-PW){prod_q[l][PW-1]}}, prod_q[l]}
                 + ({{(ACC_WIDTH-DATA_WIDTH){add_q[l][DATA_WIDTH-1]}}, add_q[l]} << FRAC_BITS);
      end else begin
        sum_c[l] = acc_q[l] + {{(ACC_WIDTH-PW){prod_q[l][PW-1]}}, prod_q[l]};
      end
      rnd_c[l] = (sum_c[l] + RND) >>> FRAC_BITS;
      if (rnd_c[l] > SAT_MAX) begin
        res_c[l*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
      end else if (rnd_c[l] < SAT_MIN) begin
        res_c[l*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
        res_c[l*DATA_WIDTH +: DATA_WIDTH] = rnd_c[l][DATA_WIDTH-1:0];
      end
    end
  end

  // Configuration registers; length and mode are frozen while busy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q  <= LEN_WIDTH'(1);
      mode_q <= MODE_CONV;
      for (int unsigned l = 0; l < LANES; l++) begin
        mul_q[l] <= '0;
        add_q[l] <= '0;
      end
    end else begin
      if (do_len && !busy) begin
        len_q <= (bus.param_i == '0) ? LEN_WIDTH'(1) : bus.param_i;
      end
      if (do_mode && !busy) begin
        mode_q <= mode_e'(bus.param_i[0]);
      end
      for (int unsigned l = 0; l < LANES; l++) begin
        if (do_mul) mul_q[l] <= bus.param_vec_i[l*DATA_WIDTH +: DATA_WIDTH];
        if (do_add) add_q[l] <= bus.param_vec_i[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // S1 register: product capture on TRIGGER, held during stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      for (int unsigned l = 0; l < LANES; l++) prod_q[l] <= '0;
    end else if (do_clear) begin
      s1_valid_q <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= do_trig;
      if (do_trig) begin
        for (int unsigned l = 0; l < LANES; l++) prod_q[l] <= prod_c[l];
      end
    end
  end

  // Accumulators and term counter; the final term bypasses the accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else if (do_clear) begin
      cnt_q <= '0;
      for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else if (do_load && !busy) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        acc_q[l] <= {{(ACC_WIDTH-DATA_WIDTH){bus.param_vec_i[l*DATA_WIDTH+DATA_WIDTH-1]}},
                     bus.param_vec_i[l*DATA_WIDTH +: DATA_WIDTH]} << FRAC_BITS;
      end
    end else if (s2_fire && (mode_q == MODE_CONV)) begin
      if (last_term) begin
        cnt_q <= '0;
        for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= '0;
      end else begin
        cnt_q <= cnt_q + LEN_WIDTH'(1);
        for (int unsigned l = 0; l < LANES; l++) acc_q[l] <= sum_c[l];
      end
    end
  end

  // Result register and status flags. Outside a stall the held result is either
  // absent or being transferred, so valid simply follows the new-load strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q    <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else if (do_clear) begin
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else if (!stall) begin
      res_valid_q <= res_load;
      if (res_load) result_q <= res_c;
      if (do_trig) begin
        busy_q <= 1'b1;
      end else if (res_load) begin
        busy_q <= 1'b0;
      end
      if ((do_len || do_mode || do_load) && busy) cfg_err_q <= 1'b1;
    end
  end

  // Neighbour pass-through of activations and weight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q   <= '0;
      weight_q <= '0;
    end else if (do_trig || do_fwd) begin
      data_q   <= bus.data_i;
      weight_q <= bus.weight_i;
    end
  end

  assign bus.cmd_ready_o    = !stall;
  assign bus.data_o         = data_q;
  assign bus.weight_o       = weight_q;
  assign bus.result_o       = result_q;
  assign bus.result_valid_o = res_valid_q;
  assign bus.busy_o         = busy;
  assign bus.cfg_err_o      = cfg_err_q;

endmodule

// File: tb/tb_pe_mac_array.sv
// Directed bench for pe_mac_array: single-term vector table plus hand-written
// sequences for grouping, saturation, FIX_MAC streaming, backpressure, guard and reset.
module tb_pe_mac_array;

  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = 16;

  localparam logic [3:0] C_NOP = 4'd0, C_CLEAR = 4'd1, C_TRIG = 4'd2, C_FWD = 4'd3,
                         C_LEN = 4'd4, C_MUL = 4'd5, C_ADD = 4'd6, C_MODE = 4'd7,
                         C_LOAD = 4'd8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pe_mac_array_if #(.LANES(LANES), .DATA_WIDTH(DW), .LEN_WIDTH(16)) bus ();

  pe_mac_array #(
    .LANES(LANES), .DATA_WIDTH(DW), .FRAC_BITS(8), .ACC_WIDTH(40), .LEN_WIDTH(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [15:0] weight;
    logic [63:0] expect_res;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic [15:0] p, input logic [63:0] pv,
                      input logic [63:0] d, input logic [15:0] w);
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_i       = c;
    bus.param_i     = p;
    bus.param_vec_i = pv;
    bus.data_i      = d;
    bus.weight_i    = w;
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_i       = C_NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{data: {16'h0080, 16'hFF00, 16'h0200, 16'h0100}, weight: 16'h0100,
                expect_res: {16'h0080, 16'hFF00, 16'h0200, 16'h0100}};
    vecs[1] = '{data: {16'h7FFF, 16'hFFFF, 16'h0003, 16'h0001}, weight: 16'h0080,
                expect_res: {16'h4000, 16'h0000, 16'h0002, 16'h0001}};
    vecs[2] = '{data: {16'h0180, 16'h0000, 16'h8000, 16'h7F00}, weight: 16'h7F00,
                expect_res: {16'h7FFF, 16'h0000, 16'h8000, 16'h7FFF}};
    vecs[3] = '{data: {16'hFE00, 16'h0040, 16'h0100, 16'hFF80}, weight: 16'hFF00,
                expect_res: {16'h0200, 16'hFFC0, 16'hFF00, 16'h0080}};

    bus.cmd_valid_i    = 1'b0;
    bus.cmd_i          = C_NOP;
    bus.param_i        = '0;
    bus.param_vec_i    = '0;
    bus.data_i         = '0;
    bus.weight_i       = '0;
    bus.result_ready_i = 1'b1;
    rst_n              = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_valid", 64'(bus.result_valid_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_cfg_err", 64'(bus.cfg_err_o), 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    check("rst_result", bus.result_o, 64'd0);
    check("rst_data_o", bus.data_o, 64'd0);

    // CONV dot product over 3 terms
    send(C_LEN, 16'd3, '0, '0, '0);
    send(C_TRIG, '0, '0, rep(16'h0100), 16'h0200);
    check("dot_busy_set", 64'(bus.busy_o), 64'd1);
    send(C_TRIG, '0, '0, rep(16'h0100), 16'h0100);
    check("dot_no_early_valid", 64'(bus.result_valid_o), 64'd0);
    send(C_TRIG, '0, '0, rep(16'h0100), 16'h0080);
    check("dot_valid_lat1", 64'(bus.result_valid_o), 64'd0);
    check("dot_weight_o", 64'(bus.weight_o), 64'h0080);
    tick();
    check("dot_result", bus.result_o, rep(16'h0380));
    check("dot_valid", 64'(bus.result_valid_o), 64'd1);
    check("dot_busy_fall", 64'(bus.busy_o), 64'd0);
    tick();
    check("dot_valid_drop", 64'(bus.result_valid_o), 64'd0);

    // Saturation, two terms
    send(C_LEN, 16'd2, '0, '0, '0);
    send(C_TRIG, '0, '0, rep(16'h7F00), 16'h7F00);
    send(C_TRIG, '0, '0, rep(16'h7F00), 16'h7F00);
    tick();
    check("sat_pos", bus.result_o, rep(16'h7FFF));
    send(C_TRIG, '0, '0, rep(16'h8100), 16'h7F00);
    send(C_TRIG, '0, '0, rep(16'h8100), 16'h7F00);
    tick();
    check("sat_neg", bus.result_o, rep(16'h8000));

    // Rounding, single term
    send(C_LEN, 16'd1, '0, '0, '0);
    send(C_TRIG, '0, '0, rep(16'h0001), 16'h0080);
    tick();
    check("round_half_up", bus.result_o, rep(16'h0001));

    // Single-term vector table
    for (int i = 0; i < 4; i++) begin
      send(C_TRIG, '0, '0, vecs[i].data, vecs[i].weight);
      check($sformatf("vec%0d_data_o", i), bus.data_o, vecs[i].data);
      tick();
      check($sformatf("vec%0d_result", i), bus.result_o, vecs[i].expect_res);
      check($sformatf("vec%0d_valid", i), 64'(bus.result_valid_o), 64'd1);
    end
    tick();

    // FORWARD passes data but starts no MAC
    send(C_FWD, '0, '0, 64'h1234_5678_9ABC_DEF0, 16'h5555);
    check("fwd_data_o", bus.data_o, 64'h1234_5678_9ABC_DEF0);
    check("fwd_weight_o", 64'(bus.weight_o), 64'h5555);
    tick();
    check("fwd_no_result", 64'(bus.result_valid_o), 64'd0);

    // FIX_MAC streaming, back-to-back triggers
    send(C_MODE, 16'd1, '0, '0, '0);
    send(C_MUL, '0, rep(16'h0200), '0, '0);
    send(C_ADD, '0, rep(16'h0080), '0, '0);
    send(C_TRIG, '0, '0, rep(16'h0100), 16'h7777);
    check("fix_t1_valid", 64'(bus.result_valid_o), 64'd0);
    check("fix_busy", 64'(bus.busy_o), 64'd1);
    for (int k = 0; k < 3; k++) begin
      send(C_TRIG, '0, '0, rep(16'h0100), 16'h7777);
      check($sformatf("fix_r%0d_valid", k), 64'(bus.result_valid_o), 64'd1);
      check($sformatf("fix_r%0d", k), bus.result_o, rep(16'h0280));
    end
    tick();
    check("fix_r3_valid", 64'(bus.result_valid_o), 64'd1);
    check("fix_r3", bus.result_o, rep(16'h0280));
    tick();
    check("fix_end_valid", 64'(bus.result_valid_o), 64'd0);
    send(C_MODE, 16'd0, '0, '0, '0);

    // Backpressure
    bus.result_ready_i = 1'b0;
    send(C_TRIG, '0, '0, {16'h0400, 16'h0300, 16'h0200, 16'h0100}, 16'h0100);
    tick();
    check("bp_valid", 64'(bus.result_valid_o), 64'd1);
    check("bp_result", bus.result_o, {16'h0400, 16'h0300, 16'h0200, 16'h0100});
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_i       = C_TRIG;
    bus.data_i      = rep(16'h0100);
    bus.weight_i    = 16'h0500;
    #1;
    check("bp_cmd_ready_low", 64'(bus.cmd_ready_o), 64'd0);
    tick();
    tick();
    check("bp_hold_result", bus.result_o, {16'h0400, 16'h0300, 16'h0200, 16'h0100});
    check("bp_hold_valid", 64'(bus.result_valid_o), 64'd1);
    check("bp_hold_data_o", bus.data_o, {16'h0400, 16'h0300, 16'h0200, 16'h0100});
    @(negedge clk);
    bus.result_ready_i = 1'b1;
    #1;
    check("bp_ready_release", 64'(bus.cmd_ready_o), 64'd1);
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_i       = C_NOP;
    check("bp_one_transfer", 64'(bus.result_valid_o), 64'd0);
    check("bp_cmd_ready_after", 64'(bus.cmd_ready_o), 64'd1);
    tick();
    check("bp_second_result", bus.result_o, rep(16'h0500));
    check("bp_second_valid", 64'(bus.result_valid_o), 64'd1);
    tick();

    // Accumulator preload as bias
    send(C_LOAD, '0, rep(16'h0100), '0, '0);
    send(C_TRIG, '0, '0, rep(16'h0100), 16'h0100);
    tick();
    check("bias_result", bus.result_o, rep(16'h0200));
    tick();

    // Config guard mid-group
    send(C_LEN, 16'd3, '0, '0, '0);
    send(C_TRIG, '0, '0, rep(16'h0100), 16'h0100);
    send(C_LEN, 16'd1, '0, '0, '0);
    check("guard_cfg_err", 64'(bus.cfg_err_o), 64'd1);
    tick();
    check("guard_len_ignored", 64'(bus.result_valid_o), 64'd0);
    send(C_TRIG, '0, '0, rep(16'h0100), 16'h0100);
    send(C_TRIG, '0, '0, rep(16'h0100), 16'h0100);
    tick();
    check("guard_group_result", bus.result_o, rep(16'h0300));
    check("guard_cfg_err_sticky", 64'(bus.cfg_err_o), 64'd1);
    send(C_CLEAR, '0, '0, '0, '0);
    check("clear_cfg_err", 64'(bus.cfg_err_o), 64'd0);

    // Asynchronous reset mid-group (LEN still 3)
    send(C_TRIG, '0, '0, rep(16'h0100), 16'h0100);
    send(C_TRIG, '0, '0, rep(16'h0100), 16'h0100);
    check("ar_busy_before", 64'(bus.busy_o), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_data_o", bus.data_o, 64'd0);
    check("ar_weight_o", 64'(bus.weight_o), 64'd0);
    check("ar_result_o", bus.result_o, 64'd0);
    check("ar_busy", 64'(bus.busy_o), 64'd0);
    check("ar_valid", 64'(bus.result_valid_o), 64'd0);
    #1 rst_n = 1'b1;
    send(C_TRIG, '0, '0, rep(16'h0100), 16'h0280);
    tick();
    check("ar_len1_conv_result", bus.result_o, rep(16'h0280));
    check("ar_len1_conv_valid", 64'(bus.result_valid_o), 64'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
